// File: rtl/vga_mem_pkg.sv
// Shared frame-buffer geometry, pixel format and painter state encoding
// for the VGA frame-buffer side of the design.
package vga_mem_pkg;

  localparam int unsigned VGA_FB_W    = 160;
  localparam int unsigned VGA_FB_H    = 120;
  localparam int unsigned VGA_SQ      = 8;
  localparam int unsigned VGA_ADDR_W  = 15;
  localparam int unsigned VGA_COLOR_W = 3;
  localparam int unsigned VGA_BG      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/square_step_painter_if.sv
// Frame-buffer write port plus delay-timer en/done handshake.
interface square_step_painter_if
  import vga_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = VGA_ADDR_W,
  parameter int unsigned COLOR_W = VGA_COLOR_W
);

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               delay_en;
  logic               delay_done;

  modport master (
    output wr_en, wr_addr, wr_data, delay_en,
    input  delay_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, delay_en,
    output delay_done
  );

endinterface

// File: rtl/square_step_painter_rect_scanner.sv
// Walks an SQ x SQ rectangle of the frame buffer in raster order, one
// registered address per cycle; go restarts the walk at (x0,y0).
module rect_scanner
  import vga_mem_pkg::*;
#(
  parameter int unsigned FB_W   = VGA_FB_W,
  parameter int unsigned SQ     = VGA_SQ,
  parameter int unsigned ADDR_W = VGA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned CW = $clog2(SQ * SQ);
  localparam int unsigned XW = $clog2(SQ);
  localparam logic [CW-1:0]     CNT_LAST = CW'(SQ * SQ - 1);
  localparam logic [XW-1:0]     COL_LAST = XW'(SQ - 1);
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ROW_SKIP = ADDR_W'(FB_W - SQ + 1);

  logic [CW-1:0] cnt;

  assign last = valid && (cnt == CNT_LAST);

  // go wins over last so a new burst can follow the previous one with no gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      cnt   <= '0;
      addr  <= '0;
    end else if (go) begin
      valid <= 1'b1;
      cnt   <= '0;
      addr  <= ADDR_W'(y0) * FB_W_A + ADDR_W'(x0);
    end else if (valid) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        cnt  <= cnt + 1'b1;
        addr <= (cnt[XW-1:0] == COL_LAST) ? addr + ROW_SKIP : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_step_painter.sv
// Timer-paced animation: erase the square, step it one cell with wrap,
// redraw it, then wait for the delay timer before the next step.
module square_step_painter
  import vga_mem_pkg::*;
#(
  parameter int unsigned FB_W    = VGA_FB_W,
  parameter int unsigned FB_H    = VGA_FB_H,
  parameter int unsigned SQ      = VGA_SQ,
  parameter int unsigned ADDR_W  = VGA_ADDR_W,
  parameter int unsigned COLOR_W = VGA_COLOR_W,
  parameter int unsigned BG      = VGA_BG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [COLOR_W-1:0]    color,
  square_step_painter_if.master fb,
  output logic [7:0]            pos_x,
  output logic [7:0]            pos_y,
  output logic                  busy
);

  localparam logic [8:0] SQ9 = 9'(SQ);
  localparam logic [8:0] W9  = 9'(FB_W);
  localparam logic [8:0] H9  = 9'(FB_H);
  localparam logic [7:0] SQ8 = 8'(SQ);

  state_t state, state_n;
  logic first, done_q, done_edge;
  logic go, step;
  logic [7:0] nx, ny;
  logic scan_valid, scan_last;
  logic [ADDR_W-1:0] scan_addr;
  logic [COLOR_W-1:0] wr_data_q;
  logic delay_en_q;

  assign done_edge   = fb.delay_done & ~done_q;
  assign fb.wr_en    = scan_valid;
  assign fb.wr_addr  = scan_addr;
  assign fb.wr_data  = wr_data_q;
  assign fb.delay_en = delay_en_q;

  rect_scanner #(
    .FB_W  (FB_W),
    .SQ    (SQ),
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .x0   (nx),
    .y0   (ny),
    .valid(scan_valid),
    .addr (scan_addr),
    .last (scan_last)
  );

  // Scanner origin is the post-step position so DRAW starts right after ERASE
  always_comb begin
    nx = pos_x;
    ny = pos_y;
    if (step) begin
      if ({1'b0, pos_x} + SQ9 >= W9) begin
        nx = '0;
        ny = ({1'b0, pos_y} + SQ9 >= H9) ? '0 : pos_y + SQ8;
      end else begin
        nx = pos_x + SQ8;
      end
    end
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) begin
          go      = 1'b1;
          state_n = first ? ST_DRAW : ST_ERASE;
        end
      end
      ST_ERASE: begin
        if (scan_last) begin
          step    = 1'b1;
          go      = 1'b1;
          state_n = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (scan_last) state_n = run ? ST_WAIT_DONE : ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (done_edge) begin
          if (run) begin
            go      = 1'b1;
            state_n = ST_ERASE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      first      <= 1'b1;
      done_q     <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      busy       <= 1'b0;
      delay_en_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state      <= state_n;
      done_q     <= fb.delay_done;
      busy       <= (state_n != ST_IDLE);
      delay_en_q <= (state_n == ST_WAIT_DONE);
      pos_x      <= nx;
      pos_y      <= ny;
      if (state == ST_DRAW && scan_last) first <= 1'b0;
      if (go) wr_data_q <= (state_n == ST_DRAW) ? color : COLOR_W'(BG);
    end
  end

endmodule

// File: tb/tb_square_step_painter.sv
// Self-checking bench for square_step_painter against a pixel-level model
// of where each square should be erased and drawn.
module tb_square_step_painter;

  localparam int unsigned FB_W = 160;
  localparam int unsigned FB_H = 120;
  localparam int unsigned SQ   = 8;
  localparam int unsigned AW   = 15;
  localparam int unsigned CW   = 3;
  localparam int unsigned BG   = 0;

  logic          clk;
  logic          rst;
  logic          run;
  logic [CW-1:0] color;
  logic [7:0]    pos_x, pos_y;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned mx = 0, my = 0;

  square_step_painter_if #(.ADDR_W(AW), .COLOR_W(CW)) fb ();

  square_step_painter #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .SQ     (SQ),
    .ADDR_W (AW),
    .COLOR_W(CW),
    .BG     (BG)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .color(color),
    .fb   (fb),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_done(input int hold);
    fb.delay_done = 1'b1;
    repeat (hold) @(negedge clk);
    fb.delay_done = 1'b0;
  endtask

  // One full square burst, starting at the current negedge
  task automatic burst(input int unsigned x, input int unsigned y, input int unsigned data,
                       input int drop_at);
    for (int i = 0; i < int'(SQ * SQ); i++) begin
      check("wr_en", fb.wr_en, 1);
      check("wr_addr", fb.wr_addr, (y + i / SQ) * FB_W + x + i % SQ);
      check("wr_data", fb.wr_data, data);
      check("delay_en_in_burst", fb.delay_en, 0);
      check("busy_in_burst", busy, 1);
      if (i == drop_at) run = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic model_step();
    if (mx + SQ >= FB_W) begin
      mx = 0;
      my = (my + SQ >= FB_H) ? 0 : my + SQ;
    end else begin
      mx = mx + SQ;
    end
  endtask

  task automatic check_waiting(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("wait_delay_en", fb.delay_en, 1);
      check("wait_wr_en", fb.wr_en, 0);
      @(negedge clk);
    end
  endtask

  task automatic period(input int hold, input int unsigned c);
    color = CW'(c);
    fork
      pulse_done(hold);
    join_none
    @(negedge clk);
    check("delay_en_drop", fb.delay_en, 0);
    burst(mx, my, BG, -1);
    model_step();
    check("pos_x", pos_x, mx);
    check("pos_y", pos_y, my);
    burst(mx, my, c, -1);
    check("post_draw_delay_en", fb.delay_en, 1);
    check("post_draw_wr_en", fb.wr_en, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, fb.wr_en, 0);
    check({tag, "_wr_addr"}, fb.wr_addr, 0);
    check({tag, "_wr_data"}, fb.wr_data, 0);
    check({tag, "_delay_en"}, fb.delay_en, 0);
    check({tag, "_pos_x"}, pos_x, 0);
    check({tag, "_pos_y"}, pos_y, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int unsigned c;
    rst = 1'b0;
    run = 1'b0;
    color = 3'd5;
    fb.delay_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wr_en", fb.wr_en, 0);
    check("idle_busy", busy, 0);

    // First run draws directly with no erase burst
    run = 1'b1;
    @(negedge clk);
    burst(0, 0, 5, -1);
    check("first_delay_en", fb.delay_en, 1);
    check("first_wr_en_off", fb.wr_en, 0);
    check_waiting(3);

    period(1, 5);
    check("step1_pos_x", pos_x, 8);
    check_waiting(2);

    // Held-high done: exactly one erase/draw pair
    period(3, $urandom_range(0, 7));
    check_waiting(12);

    while (!(mx == 152 && my == 112)) begin
      check_waiting($urandom_range(0, 3));
      period($urandom_range(1, 4), $urandom_range(0, 7));
    end
    check("wrap_pre_x", pos_x, 152);
    check("wrap_pre_y", pos_y, 112);
    period($urandom_range(1, 4), $urandom_range(0, 7));
    check("wrap_x", pos_x, 0);
    check("wrap_y", pos_y, 0);

    // Drop run mid-draw
    c = $urandom_range(0, 7);
    color = CW'(c);
    fork
      pulse_done(1);
    join_none
    @(negedge clk);
    burst(mx, my, BG, -1);
    model_step();
    burst(mx, my, c, 19);
    check("drop_busy", busy, 0);
    check("drop_delay_en", fb.delay_en, 0);
    check("drop_wr_en", fb.wr_en, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stopped_delay_en", fb.delay_en, 0);
      check("stopped_wr_en", fb.wr_en, 0);
      check("stopped_pos_x", pos_x, mx);
    end
    run = 1'b1;
    c = $urandom_range(0, 7);
    color = CW'(c);
    @(negedge clk);
    burst(mx, my, BG, -1);
    model_step();
    check("resume_pos_x", pos_x, mx);
    burst(mx, my, c, -1);
    check("resume_delay_en", fb.delay_en, 1);

    // Reset in the middle of an erase burst
    fork
      pulse_done(1);
    join_none
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("pre_rst_wr_addr", fb.wr_addr, (my + i / SQ) * FB_W + mx + i % SQ);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("async_rst_wr_en", fb.wr_en, 0);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    c = $urandom_range(0, 7);
    color = CW'(c);
    rst = 1'b1;
    mx = 0;
    my = 0;
    @(negedge clk);
    burst(0, 0, c, -1);
    check("after_rst_delay_en", fb.delay_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
